// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host command sequencer and its receive-side neighbours:
// FSM encoding, APB register map, status bit positions and the frame bit selector.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INHIBIT  = 3'd1,
        ST_RTS      = 3'd2,
        ST_SHIFT    = 3'd3,
        ST_ACK      = 3'd4,
        ST_WAIT_REL = 3'd5
    } ps2_state_t;

    localparam logic [3:0] OFF_CMD    = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_ACK_OK  = 1;
    localparam int STAT_NACK    = 2;
    localparam int STAT_TIMEOUT = 3;

    // Bit presented on the line for frame index idx: 0-7 data LSB first, 8 odd parity, 9 stop.
    function automatic logic tx_bit(input logic [7:0] d, input logic [3:0] idx);
        if (idx < 4'd8) begin
            return d[idx[2:0]];
        end else if (idx == 4'd8) begin
            return ~^d;
        end else begin
            return 1'b1;
        end
    endfunction

endpackage

// File: rtl/ps2_clk_sync.sv
// Three-flop synchroniser for the PS/2 clock pad with a one-cycle falling-edge pulse.
// Shared with the receive path so both sides see the same edge timing.
module ps2_clk_sync (
    input  logic clock,
    input  logic reset,
    input  logic ps2_clk,
    output logic clk_sync,
    output logic clk_fall
);

    logic [2:0] s;

    // Flops reset high (idle bus) so leaving reset never fabricates an edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s <= 3'b111;
        end else begin
            s <= {s[1:0], ps2_clk};
        end
    end

    assign clk_sync = s[1];
    assign clk_fall = s[2] & ~s[1];

endmodule

// File: rtl/ps2_host_tx_ctrl.sv
// APB-programmable PS/2 host-to-device command sender: clock inhibit, request-to-send,
// 8 data bits + odd parity + stop, ack sampling, then hand the bus back to the receiver.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | pads released, receive path owns the bus
// INHIBIT  | ps2_clk held low for INHIBIT_CYCLES
// RTS      | start bit driven (data low), waiting for first device clock
// SHIFT    | data/parity/stop presented on successive device clock falls
// ACK      | pads released, ack sampled on the next fall
// WAIT_REL | waiting for device to release clock and data
module ps2_host_tx_ctrl
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int CNT_W          = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_paddr,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic [2:0]  in_pprot,
    input  logic        in_pwrite,
    input  logic [31:0] in_pwdata,
    input  logic [3:0]  in_pstrb,
    output logic        in_pready,
    output logic [31:0] in_prdata,
    output logic        in_pslverr,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic        ps2_clk_oe,
    output logic        ps2_data_oe,
    output logic        rx_inhibit
);

    localparam logic [CNT_W-1:0] INH_LOAD = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ps2_state_t       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [3:0]       idx, idx_d;
    logic [7:0]       data_q, data_d;
    logic             ack_ok_q, ack_ok_d;
    logic             nack_q, nack_d;
    logic             timeout_q, timeout_d;

    logic       clk_sync, clk_fall;
    logic [1:0] data_s;
    logic       data_sync;

    logic        access, busy, cmd_accept;
    logic [1:0]  reg_sel;
    logic [31:0] status_word;
    logic        unused_apb;

    ps2_clk_sync u_clk_sync (
        .clock    (clock),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .clk_sync (clk_sync),
        .clk_fall (clk_fall)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_s <= 2'b11;
        end else begin
            data_s <= {data_s[0], ps2_data};
        end
    end
    assign data_sync = data_s[1];

    // APB decode: zero wait state, everything happens in the access phase.
    assign access     = in_psel & in_penable;
    assign reg_sel    = in_paddr[3:2];
    assign busy       = (state != ST_IDLE);
    assign cmd_accept = access & in_pwrite & (reg_sel == OFF_CMD[3:2]) & ~busy;

    always_comb begin
        status_word               = '0;
        status_word[STAT_BUSY]    = busy;
        status_word[STAT_ACK_OK]  = ack_ok_q;
        status_word[STAT_NACK]    = nack_q;
        status_word[STAT_TIMEOUT] = timeout_q;
    end

    assign in_pready  = access;
    assign in_prdata  = (access & ~in_pwrite & (reg_sel == OFF_STATUS[3:2])) ? status_word : 32'd0;
    assign in_pslverr = access & ( reg_sel[1]
                                 | (in_pwrite & (reg_sel == OFF_STATUS[3:2]))
                                 | (in_pwrite & (reg_sel == OFF_CMD[3:2]) & busy));

    assign unused_apb = ^{in_paddr[31:4], in_paddr[1:0], in_pwdata[31:8], in_pprot, in_pstrb};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            idx       <= '0;
            data_q    <= '0;
            ack_ok_q  <= 1'b0;
            nack_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            idx       <= idx_d;
            data_q    <= data_d;
            ack_ok_q  <= ack_ok_d;
            nack_q    <= nack_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        idx_d       = idx;
        data_d      = data_q;
        ack_ok_d    = ack_ok_q;
        nack_d      = nack_q;
        timeout_d   = timeout_q;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cmd_accept) begin
                    data_d    = in_pwdata[7:0];
                    ack_ok_d  = 1'b0;
                    nack_d    = 1'b0;
                    timeout_d = 1'b0;
                    cnt_d     = INH_LOAD;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (cnt == '0) begin
                    cnt_d   = TO_LOAD;
                    state_d = ST_RTS;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            ST_RTS: begin
                ps2_data_oe = 1'b1;
                if (clk_fall) begin
                    idx_d   = 4'd0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ps2_data_oe = ~tx_bit(data_q, idx);
                // The fall after parity presents stop; stop is simply the released line in ACK.
                if (clk_fall) begin
                    if (idx == 4'd8) begin
                        idx_d   = 4'd9;
                        state_d = ST_ACK;
                    end else begin
                        idx_d = idx + 4'd1;
                    end
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    ack_ok_d = ~data_sync;
                    nack_d   = data_sync;
                    state_d  = ST_WAIT_REL;
                end
            end
            ST_WAIT_REL: begin
                if (clk_sync && data_sync) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Timeout overrides anything a coincident fall would have done this cycle.
        if (state inside {ST_RTS, ST_SHIFT, ST_ACK, ST_WAIT_REL}) begin
            if (cnt == '0) begin
                ack_ok_d  = ack_ok_q;
                nack_d    = nack_q;
                timeout_d = 1'b1;
                idx_d     = 4'd0;
                state_d   = ST_IDLE;
            end else begin
                cnt_d = cnt - CNT_ONE;
            end
        end
    end

    assign rx_inhibit = busy;

endmodule

// File: tb/tb_ps2_host_tx_ctrl.sv
// Directed + randomized bench for ps2_host_tx_ctrl with a PS/2 device model on open-drain pads.
module tb_ps2_host_tx_ctrl;

    localparam int INH = 8;
    localparam int TMO = 200;

    logic        clock;
    logic        reset;
    logic [31:0] in_paddr;
    logic        in_psel;
    logic        in_penable;
    logic [2:0]  in_pprot;
    logic        in_pwrite;
    logic [31:0] in_pwdata;
    logic [3:0]  in_pstrb;
    logic        in_pready;
    logic [31:0] in_prdata;
    logic        in_pslverr;
    logic        ps2_clk_oe;
    logic        ps2_data_oe;
    logic        rx_inhibit;
    logic        ps2_clk_pad;
    logic        ps2_data_pad;

    logic        dev_clk_low;
    logic        dev_data_low;
    logic        dev_abort;
    logic [9:0]  dev_bits;
    logic [31:0] fork_rd;
    logic        fork_err;
    logic        fork_rdy;

    int checks;
    int errors;

    assign ps2_clk_pad  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_pad = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx_ctrl #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (20)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_paddr    (in_paddr),
        .in_psel     (in_psel),
        .in_penable  (in_penable),
        .in_pprot    (in_pprot),
        .in_pwrite   (in_pwrite),
        .in_pwdata   (in_pwdata),
        .in_pstrb    (in_pstrb),
        .in_pready   (in_pready),
        .in_prdata   (in_prdata),
        .in_pslverr  (in_pslverr),
        .ps2_clk     (ps2_clk_pad),
        .ps2_data    (ps2_data_pad),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .rx_inhibit  (rx_inhibit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Reference frame as the device should see it: {stop, odd parity, data LSB first}.
    function automatic logic [9:0] frame_model(input logic [7:0] b);
        int ones = $countones(b);
        return {1'b1, ((ones % 2) == 0), b};
    endfunction

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data,
                             output logic err, output logic rdy);
        cyc(1);
        in_paddr   = addr;
        in_pwdata  = data;
        in_pwrite  = 1'b1;
        in_psel    = 1'b1;
        in_penable = 1'b0;
        cyc(1);
        in_penable = 1'b1;
        @(negedge clock);
        err = in_pslverr;
        rdy = in_pready;
        @(posedge clock);
        #1;
        in_psel    = 1'b0;
        in_penable = 1'b0;
        in_pwrite  = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic err, output logic rdy);
        cyc(1);
        in_paddr   = addr;
        in_pwrite  = 1'b0;
        in_psel    = 1'b1;
        in_penable = 1'b0;
        cyc(1);
        in_penable = 1'b1;
        @(negedge clock);
        data = in_prdata;
        err  = in_pslverr;
        rdy  = in_pready;
        @(posedge clock);
        #1;
        in_psel    = 1'b0;
        in_penable = 1'b0;
    endtask

    // Device: 10-cycle clock, samples each bit at the end of the high phase, 11th fall is the ack.
    task automatic device(input logic drive_ack);
        dev_bits = '0;
        cyc(4);
        for (int f = 1; f <= 11; f++) begin
            if (dev_abort) break;
            if (f >= 2) dev_bits[f-2] = ps2_data_pad;
            if (f == 11 && drive_ack) begin
                dev_data_low = 1'b1;
                cyc(1);
            end
            dev_clk_low = 1'b1;
            cyc(5);
            dev_clk_low = 1'b0;
            cyc(1);
            dev_data_low = 1'b0;
            cyc(4);
        end
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
    endtask

    task automatic count_inhibit(output int n);
        n = 0;
        @(negedge clock);
        while (ps2_clk_oe && n < 1000) begin
            n++;
            @(negedge clock);
        end
    endtask

    task automatic wait_idle(input int maxc, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (!rx_inhibit) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic ack, input string tag);
        logic        err, rdy, ok;
        logic [31:0] rd;
        int          n;
        apb_write(32'h0, {24'd0, b}, err, rdy);
        check({tag, "_cmd_err"}, {31'd0, err}, 32'd0);
        count_inhibit(n);
        check({tag, "_inhibit_len"}, n, INH);
        check({tag, "_rts_data_oe"}, {31'd0, ps2_data_oe}, 32'd1);
        fork
            device(ack);
            apb_read(32'h4, fork_rd, fork_err, fork_rdy);
        join
        check({tag, "_status_busy"}, fork_rd, 32'h1);
        wait_idle(100, ok);
        check({tag, "_done"}, {31'd0, ok}, 32'd1);
        check({tag, "_bits"}, {22'd0, dev_bits}, {22'd0, frame_model(b)});
        apb_read(32'h4, rd, err, rdy);
        check({tag, "_status_end"}, rd, ack ? 32'h2 : 32'h4);
        check({tag, "_rx_inhibit"}, {31'd0, rx_inhibit}, 32'd0);
    endtask

    initial begin
        logic        err, rdy, ok;
        logic [31:0] rd;
        int          n;
        logic [7:0]  rb;
        logic        ra;

        checks       = 0;
        errors       = 0;
        reset        = 1'b0;
        in_paddr     = '0;
        in_psel      = 1'b0;
        in_penable   = 1'b0;
        in_pprot     = '0;
        in_pwrite    = 1'b0;
        in_pwdata    = '0;
        in_pstrb     = 4'hF;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        dev_abort    = 1'b0;
        dev_bits     = '0;

        #2;
        check("rst_clk_oe",  {31'd0, ps2_clk_oe},  32'd0);
        check("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        check("rst_rx_inh",  {31'd0, rx_inhibit},  32'd0);
        check("rst_pready",  {31'd0, in_pready},   32'd0);
        check("rst_prdata",  in_prdata,            32'd0);
        check("rst_pslverr", {31'd0, in_pslverr},  32'd0);
        cyc(3);
        reset = 1'b1;
        cyc(2);

        apb_read(32'h4, rd, err, rdy);
        check("status_after_reset", rd, 32'h0);

        send_frame(8'hED, 1'b1, "ed_ack");
        send_frame(8'hFF, 1'b0, "ff_nack");

        // No device clocks: RTS must time out after TMO cycles.
        apb_write(32'h0, 32'h00, err, rdy);
        count_inhibit(n);
        check("to_inhibit_len", n, INH);
        check("to_rts_data_oe", {31'd0, ps2_data_oe}, 32'd1);
        n = 0;
        while (rx_inhibit && n < 1000) begin
            n++;
            @(negedge clock);
        end
        check("to_cycles", n, TMO);
        check("to_clk_oe",  {31'd0, ps2_clk_oe},  32'd0);
        check("to_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        apb_read(32'h4, rd, err, rdy);
        check("to_status", rd, 32'h8);

        // Command write while shifting is refused and does not disturb the frame.
        apb_write(32'h0, 32'hED, err, rdy);
        count_inhibit(n);
        check("busy_inhibit_len", n, INH);
        fork
            device(1'b1);
            begin
                cyc(40);
                apb_write(32'h0, 32'h55, fork_err, fork_rdy);
            end
        join
        check("busy_wr_err", {31'd0, fork_err}, 32'd1);
        wait_idle(100, ok);
        check("busy_done", {31'd0, ok}, 32'd1);
        check("busy_bits", {22'd0, dev_bits}, {22'd0, frame_model(8'hED)});
        apb_read(32'h4, rd, err, rdy);
        check("busy_status", rd, 32'h2);

        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom_range(0, 255));
            ra = 1'($urandom_range(0, 1));
            send_frame(rb, ra, "rnd");
        end

        // Asynchronous reset mid-shift drops every pad control before the next edge.
        apb_write(32'h0, 32'hED, err, rdy);
        count_inhibit(n);
        fork
            device(1'b1);
            begin
                cyc(40);
                #3;
                check("ars_rx_inh_before", {31'd0, rx_inhibit}, 32'd1);
                reset = 1'b0;
                #1;
                check("ars_clk_oe",  {31'd0, ps2_clk_oe},  32'd0);
                check("ars_data_oe", {31'd0, ps2_data_oe}, 32'd0);
                check("ars_rx_inh",  {31'd0, rx_inhibit},  32'd0);
                dev_abort = 1'b1;
            end
        join
        dev_abort = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(2);
        apb_read(32'h4, rd, err, rdy);
        check("ars_status", rd, 32'h0);

        apb_write(32'h8, 32'h1234, err, rdy);
        check("wr8_err", {31'd0, err}, 32'd1);
        check("wr8_rdy", {31'd0, rdy}, 32'd1);
        apb_write(32'h4, 32'hF, err, rdy);
        check("wrstat_err", {31'd0, err}, 32'd1);
        check("wrstat_rdy", {31'd0, rdy}, 32'd1);
        apb_read(32'h8, rd, err, rdy);
        check("rd8_data", rd, 32'h0);
        check("rd8_err", {31'd0, err}, 32'd1);
        apb_read(32'h0, rd, err, rdy);
        check("rdcmd_data", rd, 32'h0);
        check("idle_rx_inh", {31'd0, rx_inhibit}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
